// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX operand pipeline register, one-deep writeback
// history, and the EX-stage forwarding muxes that produce the ALU operands.
module ex_operand_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rn,
  input  logic [REG_W-1:0]  id_rm,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_regwrite,
  input  logic [DATA_W-1:0] id_rdata_a,
  input  logic [DATA_W-1:0] id_rdata_b,
  input  logic [1:0]        ForwardA,
  input  logic [1:0]        ForwardB,
  input  logic [DATA_W-1:0] exmem_alu_result,
  input  logic [DATA_W-1:0] memwb_wb_data,
  input  logic [REG_W-1:0]  memwb_rd,
  input  logic              memwb_regwrite,
  output logic [REG_W-1:0]  IDEXrn,
  output logic [REG_W-1:0]  IDEXrm,
  output logic [REG_W-1:0]  IDEXrd,
  output logic              IDEXregwrite,
  output logic              idex_valid,
  output logic [REG_W-1:0]  prevdestreg_1,
  output logic              prevWE_1,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b
);

  // XZR index; used as the "no register" value for bubbles and reset.
  localparam logic [REG_W-1:0] XZR = REG_W'(31);

  // Forwarding select encoding.
  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_EXM  = 2'b10;
  localparam logic [1:0] FWD_PREV = 2'b11;

  // ID/EX state
  logic [REG_W-1:0]  rn_q, rn_d;
  logic [REG_W-1:0]  rm_q, rm_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              regwrite_q, regwrite_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_a_q, data_a_d;
  logic [DATA_W-1:0] data_b_q, data_b_d;

  // Writeback history state
  logic [REG_W-1:0]  prev_rd_q;
  logic              prev_we_q;
  logic [DATA_W-1:0] prev_data_q;

  // A held operand is stale if the instruction retiring now writes its source.
  logic refresh_a, refresh_b;
  assign refresh_a = memwb_regwrite && (memwb_rd != XZR) && (memwb_rd == rn_q);
  assign refresh_b = memwb_regwrite && (memwb_rd != XZR) && (memwb_rd == rm_q);

  // ID/EX next state: flush beats stall beats capture.
  always_comb begin
    rn_d       = rn_q;
    rm_d       = rm_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    valid_d    = valid_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    if (flush) begin
      rn_d       = XZR;
      rm_d       = XZR;
      rd_d       = XZR;
      regwrite_d = 1'b0;
      valid_d    = 1'b0;
      data_a_d   = '0;
      data_b_d   = '0;
    end else if (stall) begin
      if (refresh_a) data_a_d = memwb_wb_data;
      if (refresh_b) data_b_d = memwb_wb_data;
    end else begin
      rn_d       = id_rn;
      rm_d       = id_rm;
      rd_d       = id_rd;
      regwrite_d = id_regwrite & id_valid;
      valid_d    = id_valid;
      data_a_d   = id_rdata_a;
      data_b_d   = id_rdata_b;
    end
  end

  // ID/EX register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rn_q       <= XZR;
      rm_q       <= XZR;
      rd_q       <= XZR;
      regwrite_q <= 1'b0;
      valid_q    <= 1'b0;
      data_a_q   <= '0;
      data_b_q   <= '0;
    end else begin
      rn_q       <= rn_d;
      rm_q       <= rm_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      valid_q    <= valid_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
    end
  end

  // Writeback history: free-running one-cycle delay of MEM/WB, ignores stall/flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_rd_q   <= XZR;
      prev_we_q   <= 1'b0;
      prev_data_q <= '0;
    end else begin
      prev_rd_q   <= memwb_rd;
      prev_we_q   <= memwb_regwrite;
      prev_data_q <= memwb_wb_data;
    end
  end

  // Operand A forwarding mux.
  always_comb begin
    op_a = data_a_q;
    case (ForwardA)
      FWD_REG:  op_a = data_a_q;
      FWD_WB:   op_a = memwb_wb_data;
      FWD_EXM:  op_a = exmem_alu_result;
      FWD_PREV: op_a = prev_data_q;
      default:  op_a = data_a_q;
    endcase
  end

  // Operand B forwarding mux.
  always_comb begin
    op_b = data_b_q;
    case (ForwardB)
      FWD_REG:  op_b = data_b_q;
      FWD_WB:   op_b = memwb_wb_data;
      FWD_EXM:  op_b = exmem_alu_result;
      FWD_PREV: op_b = prev_data_q;
      default:  op_b = data_b_q;
    endcase
  end

  assign IDEXrn        = rn_q;
  assign IDEXrm        = rm_q;
  assign IDEXrd        = rd_q;
  assign IDEXregwrite  = regwrite_q;
  assign idex_valid    = valid_q;
  assign prevdestreg_1 = prev_rd_q;
  assign prevWE_1      = prev_we_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed vectors with literal checks, plus a
// behavioural model compared against every output on each falling edge.
module tb_ex_operand_stage;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned REG_W  = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              stall = 1'b0, flush = 1'b0, id_valid = 1'b0, id_regwrite = 1'b0;
  logic [REG_W-1:0]  id_rn = '0, id_rm = '0, id_rd = '0;
  logic [DATA_W-1:0] id_rdata_a = '0, id_rdata_b = '0;
  logic [1:0]        ForwardA = 2'b00, ForwardB = 2'b00;
  logic [DATA_W-1:0] exmem_alu_result = '0, memwb_wb_data = '0;
  logic [REG_W-1:0]  memwb_rd = '0;
  logic              memwb_regwrite = 1'b0;

  logic [REG_W-1:0]  IDEXrn, IDEXrm, IDEXrd, prevdestreg_1;
  logic              IDEXregwrite, idex_valid, prevWE_1;
  logic [DATA_W-1:0] op_a, op_b;

  int n_cmp = 0;
  int n_err = 0;

  ex_operand_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_rdata_a(id_rdata_a), .id_rdata_b(id_rdata_b),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .exmem_alu_result(exmem_alu_result), .memwb_wb_data(memwb_wb_data),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .IDEXrn(IDEXrn), .IDEXrm(IDEXrm), .IDEXrd(IDEXrd),
    .IDEXregwrite(IDEXregwrite), .idex_valid(idex_valid),
    .prevdestreg_1(prevdestreg_1), .prevWE_1(prevWE_1),
    .op_a(op_a), .op_b(op_b)
  );

  always #5 clk = ~clk;

  // Behavioural model of the pipeline contents.
  int          m_rn = 31, m_rm = 31, m_rd = 31, m_prev_rd = 31;
  bit          m_valid = 0, m_we = 0, m_prev_we = 0;
  logic [63:0] m_a = '0, m_b = '0, m_prev = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rn = 31; m_rm = 31; m_rd = 31; m_prev_rd = 31;
      m_valid = 0; m_we = 0; m_prev_we = 0;
      m_a = '0; m_b = '0; m_prev = '0;
    end else begin
      if (flush) begin
        m_rn = 31; m_rm = 31; m_rd = 31; m_valid = 0; m_we = 0; m_a = '0; m_b = '0;
      end else if (stall) begin
        if (memwb_regwrite && int'(memwb_rd) != 31 && int'(memwb_rd) == m_rn) m_a = memwb_wb_data;
        if (memwb_regwrite && int'(memwb_rd) != 31 && int'(memwb_rd) == m_rm) m_b = memwb_wb_data;
      end else begin
        m_rn = int'(id_rn); m_rm = int'(id_rm); m_rd = int'(id_rd);
        m_valid = id_valid; m_we = id_valid && id_regwrite;
        m_a = id_rdata_a; m_b = id_rdata_b;
      end
      m_prev_rd = int'(memwb_rd); m_prev_we = memwb_regwrite; m_prev = memwb_wb_data;
    end
  end

  function automatic logic [63:0] pick(input logic [1:0] sel, input logic [63:0] stored);
    case (sel)
      2'd0:    return stored;
      2'd1:    return memwb_wb_data;
      2'd2:    return exmem_alu_result;
      default: return m_prev;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("m_rn", 64'(IDEXrn), 64'(m_rn));
    chk("m_rm", 64'(IDEXrm), 64'(m_rm));
    chk("m_rd", 64'(IDEXrd), 64'(m_rd));
    chk("m_we", 64'(IDEXregwrite), 64'(m_we));
    chk("m_valid", 64'(idex_valid), 64'(m_valid));
    chk("m_prev_rd", 64'(prevdestreg_1), 64'(m_prev_rd));
    chk("m_prev_we", 64'(prevWE_1), 64'(m_prev_we));
    chk("m_op_a", op_a, pick(ForwardA, m_a));
    chk("m_op_b", op_b, pick(ForwardB, m_b));
  end

  // Advance one clock; returns just after the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(negedge clk);
    #1;
    chk("por_rn", 64'(IDEXrn), 64'd31);
    chk("por_prev_rd", 64'(prevdestreg_1), 64'd31);
    chk("por_op_a", op_a, 64'h0);
    chk("por_op_b", op_b, 64'h0);
    reset_n = 1'b1;

    // Capture and mux
    id_valid = 1; id_regwrite = 1; id_rn = 3; id_rm = 4; id_rd = 5;
    id_rdata_a = 64'h11; id_rdata_b = 64'h22;
    exmem_alu_result = 64'hAA; memwb_wb_data = 64'hBB;
    cyc();
    chk("cap_op_a_reg", op_a, 64'h11);
    chk("cap_op_b_reg", op_b, 64'h22);
    chk("cap_we", 64'(IDEXregwrite), 64'd1);
    ForwardA = 2'b10; #1;
    chk("cap_op_a_exm", op_a, 64'hAA);
    ForwardB = 2'b01; #1;
    chk("cap_op_b_wb", op_b, 64'hBB);

    // Writeback history
    memwb_rd = 7; memwb_regwrite = 1; memwb_wb_data = 64'hCC;
    cyc();
    memwb_wb_data = 64'hDD; memwb_rd = 0; memwb_regwrite = 0;
    ForwardA = 2'b11; #1;
    chk("hist_rd", 64'(prevdestreg_1), 64'd7);
    chk("hist_we", 64'(prevWE_1), 64'd1);
    chk("hist_op_a", op_a, 64'hCC);
    chk("hist_op_b_wb", op_b, 64'hDD);
    ForwardA = 2'b00; ForwardB = 2'b00;

    // Stall refresh
    id_rn = 9; id_rm = 2; id_rdata_a = 64'h10; id_rdata_b = 64'h20;
    cyc();
    chk("st_pre_a", op_a, 64'h10);
    stall = 1; memwb_rd = 9; memwb_regwrite = 1; memwb_wb_data = 64'h55;
    id_rn = 12; id_rdata_a = 64'hEEE;
    cyc();
    chk("st_rn_hold", 64'(IDEXrn), 64'd9);
    chk("st_a_refresh", op_a, 64'h55);
    chk("st_b_keep", op_b, 64'h20);
    memwb_rd = 31; memwb_wb_data = 64'h77;
    cyc();
    chk("st_a_xzr_ignored", op_a, 64'h55);
    stall = 0; memwb_regwrite = 0;

    // Both operands refreshed together
    id_rn = 8; id_rm = 8; id_rdata_a = 64'h1; id_rdata_b = 64'h2;
    cyc();
    stall = 1; memwb_rd = 8; memwb_regwrite = 1; memwb_wb_data = 64'h3C;
    cyc();
    chk("both_a", op_a, 64'h3C);
    chk("both_b", op_b, 64'h3C);

    // Flush overrides stall; history still advances
    flush = 1; id_valid = 1; id_rd = 6; id_regwrite = 1;
    memwb_rd = 3; memwb_regwrite = 1; memwb_wb_data = 64'hEE;
    cyc();
    chk("fl_valid", 64'(idex_valid), 64'd0);
    chk("fl_we", 64'(IDEXregwrite), 64'd0);
    chk("fl_rd", 64'(IDEXrd), 64'd31);
    chk("fl_prev_rd", 64'(prevdestreg_1), 64'd3);
    chk("fl_prev_we", 64'(prevWE_1), 64'd1);
    chk("fl_op_a", op_a, 64'h0);
    // Stalled bubble: an XZR writeback must not refresh the zero data
    flush = 0; memwb_rd = 31; memwb_wb_data = 64'h99;
    cyc();
    chk("xzr_rn", 64'(IDEXrn), 64'd31);
    chk("xzr_op_a", op_a, 64'h0);
    stall = 0; memwb_regwrite = 0;

    // Qualification of regwrite by valid
    id_valid = 0; id_regwrite = 1; id_rd = 10;
    cyc();
    chk("q_we", 64'(IDEXregwrite), 64'd0);
    chk("q_valid", 64'(idex_valid), 64'd0);
    chk("q_rd", 64'(IDEXrd), 64'd10);

    // Asynchronous reset mid-stream
    id_valid = 1; id_rn = 5; id_rdata_a = 64'h42; memwb_regwrite = 1; memwb_rd = 4;
    cyc();
    chk("rs_pre_rn", 64'(IDEXrn), 64'd5);
    reset_n = 0; #1;
    chk("rs_rn", 64'(IDEXrn), 64'd31);
    chk("rs_valid", 64'(idex_valid), 64'd0);
    chk("rs_prev_we", 64'(prevWE_1), 64'd0);
    chk("rs_op_a", op_a, 64'h0);
    cyc();
    reset_n = 1;
    cyc();
    chk("rs_cap_rn", 64'(IDEXrn), 64'd5);
    chk("rs_cap_op_a", op_a, 64'h42);

    // Mixed sequence checked by the model only
    for (int i = 0; i < 60; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      id_valid = 1'($urandom); id_regwrite = 1'($urandom);
      id_rn = REG_W'($urandom_range(0, 31)); id_rm = REG_W'($urandom_range(0, 31));
      id_rd = REG_W'($urandom_range(0, 31));
      id_rdata_a = {$urandom, $urandom}; id_rdata_b = {$urandom, $urandom};
      exmem_alu_result = {$urandom, $urandom}; memwb_wb_data = {$urandom, $urandom};
      memwb_rd = (i % 2 == 0) ? IDEXrn : REG_W'($urandom_range(0, 31));
      memwb_regwrite = 1'($urandom);
      ForwardA = 2'($urandom); ForwardB = 2'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
